// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive bit-decoding path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    RECEIVE = 2'd2,
    EOP     = 2'd3
  } RX_DEC_STATE;

  localparam logic LINE_J = 1'b1;
  localparam logic LINE_K = 1'b0;

  localparam int unsigned STUFF_LEN_DEFAULT = 6;

endpackage

// File: rtl/usb_nrzi_unstuffer.sv
// NRZI decoder plus bit-unstuffing decision; tracks the previous line state and run of 1s.
module usb_nrzi_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_en_i,
  input  logic line_i,
  input  logic se0_i,
  input  logic active_i,
  input  logic load_i,
  output logic decoded_o,
  output logic drop_o,
  output logic stuff_err_o
);

  logic       prev_line_q, prev_line_d;
  logic [2:0] ones_q, ones_d;
  logic       at_limit;

  assign decoded_o = (line_i == prev_line_q);
  assign at_limit  = (ones_q == 3'(STUFF_LEN));

  always_comb begin
    drop_o      = sample_en_i & active_i & ~se0_i & at_limit & ~decoded_o;
    stuff_err_o = sample_en_i & active_i & ~se0_i & at_limit & decoded_o;
    prev_line_d = prev_line_q;
    ones_d      = ones_q;
    if (sample_en_i) begin
      // SE0 leaves the line reference at J so the EOP's trailing J decodes cleanly.
      prev_line_d = se0_i ? LINE_J : line_i;
      if (load_i) begin
        ones_d = 3'd1;
      end else if (active_i && !se0_i) begin
        if (at_limit)       ones_d = 3'd0;
        else if (decoded_o) ones_d = ones_q + 3'd1;
        else                ones_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_line_q <= LINE_J;
      ones_q      <= 3'd0;
    end else begin
      prev_line_q <= prev_line_d;
      ones_q      <= ones_d;
    end
  end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: SYNC detection, NRZI decode, unstuffing and EOP detection
// on each rising edge of the recovered 12 MHz bit clock.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned SYNC_MIN_ZEROS = 5,
  parameter int unsigned STUFF_LEN      = STUFF_LEN_DEFAULT
) (
  input  logic clk48,
  input  logic RST,
  input  logic readCLK12,
  input  logic dataIn,
  input  logic se0,
  output logic bitValid,
  output logic bitData,
  output logic packetActive,
  output logic syncDetected,
  output logic eopDetected,
  output logic rxError
);

  RX_DEC_STATE state_q, state_d;
  logic [2:0]  zero_cnt_q, zero_cnt_d;
  logic        se0_seen_q, se0_seen_d;
  logic        read_clk_q;
  logic        bit_valid_q, bit_valid_d;
  logic        bit_data_q, bit_data_d;
  logic        packet_active_q, packet_active_d;
  logic        sync_q, sync_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;

  logic sample_en, is_j, is_k, sync_ok, sync_done;
  logic decoded, drop_bit, stuff_err;

  assign sample_en = readCLK12 & ~read_clk_q;
  assign is_j      = ~se0 & (dataIn == LINE_J);
  assign is_k      = ~se0 & (dataIn == LINE_K);
  assign sync_ok   = (zero_cnt_q >= 3'(SYNC_MIN_ZEROS));
  assign sync_done = sample_en & (state_q == SYNC) & ~se0 & decoded & sync_ok;

  usb_nrzi_unstuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_unstuffer (
    .clk_i       (clk48),
    .rst_i       (RST),
    .sample_en_i (sample_en),
    .line_i      (dataIn),
    .se0_i       (se0),
    .active_i    (state_q == RECEIVE),
    .load_i      (sync_done),
    .decoded_o   (decoded),
    .drop_o      (drop_bit),
    .stuff_err_o (stuff_err)
  );

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    se0_seen_d = se0_seen_q;
    if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          if (is_k) begin
            zero_cnt_d = 3'd1;
            state_d    = SYNC;
          end
        end
        SYNC: begin
          if (se0) begin
            state_d = IDLE;
          end else if (!decoded) begin
            zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : zero_cnt_q + 3'd1;
          end else begin
            state_d = sync_ok ? RECEIVE : IDLE;
          end
        end
        RECEIVE: begin
          if (se0) begin
            state_d    = EOP;
            se0_seen_d = 1'b1;
          end else if (stuff_err) begin
            state_d = IDLE;
          end
        end
        EOP: begin
          if (is_j || is_k) begin
            state_d    = IDLE;
            se0_seen_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_valid_d     = 1'b0;
    bit_data_d      = bit_data_q;
    packet_active_d = packet_active_q;
    sync_d          = 1'b0;
    eop_d           = 1'b0;
    err_d           = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        SYNC: begin
          if (sync_done) begin
            sync_d          = 1'b1;
            packet_active_d = 1'b1;
          end
        end
        RECEIVE: begin
          if (!se0) begin
            if (stuff_err) begin
              err_d           = 1'b1;
              packet_active_d = 1'b0;
            end else if (!drop_bit) begin
              bit_valid_d = 1'b1;
              bit_data_d  = decoded;
            end
          end
        end
        EOP: begin
          if (is_j || is_k) begin
            packet_active_d = 1'b0;
            if (is_j && se0_seen_q) eop_d = 1'b1;
            else                    err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk48) begin
    if (RST) begin
      state_q         <= IDLE;
      zero_cnt_q      <= 3'd0;
      se0_seen_q      <= 1'b0;
      read_clk_q      <= 1'b1;
      bit_valid_q     <= 1'b0;
      bit_data_q      <= 1'b0;
      packet_active_q <= 1'b0;
      sync_q          <= 1'b0;
      eop_q           <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      zero_cnt_q      <= zero_cnt_d;
      se0_seen_q      <= se0_seen_d;
      read_clk_q      <= readCLK12;
      bit_valid_q     <= bit_valid_d;
      bit_data_q      <= bit_data_d;
      packet_active_q <= packet_active_d;
      sync_q          <= sync_d;
      eop_q           <= eop_d;
      err_q           <= err_d;
    end
  end

  assign bitValid     = bit_valid_q;
  assign bitData      = bit_data_q;
  assign packetActive = packet_active_q;
  assign syncDetected = sync_q;
  assign eopDetected  = eop_q;
  assign rxError      = err_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard bench for usb_rx_bit_decoder: NRZI/stuffing line encoder drives the DUT,
// expected pulses are queued at stimulus time and matched as the DUT emits them.
module tb_usb_rx_bit_decoder;

  localparam logic [1:0] EV_BIT  = 2'd0;
  localparam logic [1:0] EV_SYNC = 2'd1;
  localparam logic [1:0] EV_EOP  = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic       data;
  } ev_t;

  logic clk48 = 1'b0;
  logic RST, readCLK12, dataIn, se0;
  logic bitValid, bitData, packetActive, syncDetected, eopDetected, rxError;

  int   checks   = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic line_prev;
  int   stuff_ones;

  always #5 clk48 = ~clk48;

  usb_rx_bit_decoder #(
    .SYNC_MIN_ZEROS (5),
    .STUFF_LEN      (6)
  ) dut (
    .clk48        (clk48),
    .RST          (RST),
    .readCLK12    (readCLK12),
    .dataIn       (dataIn),
    .se0          (se0),
    .bitValid     (bitValid),
    .bitData      (bitData),
    .packetActive (packetActive),
    .syncDetected (syncDetected),
    .eopDetected  (eopDetected),
    .rxError      (rxError)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One bit time: readCLK12 high for two clk48 cycles, low for two.
  task automatic send_line(input logic line, input logic s0);
    @(negedge clk48);
    readCLK12 = 1'b1;
    dataIn    = line;
    se0       = s0;
    @(negedge clk48);
    @(negedge clk48);
    readCLK12 = 1'b0;
    @(negedge clk48);
    line_prev = s0 ? 1'b1 : line;
  endtask

  task automatic send_dec(input logic b);
    send_line(b ? line_prev : ~line_prev, 1'b0);
  endtask

  task automatic send_sync(input int zeros);
    for (int i = 0; i < zeros; i++) send_dec(1'b0);
    if (zeros >= 5) push_ev(EV_SYNC, 1'b0);
    send_dec(1'b1);
    stuff_ones = 1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      push_ev(EV_BIT, v[i]);
      send_dec(v[i]);
      stuff_ones = v[i] ? stuff_ones + 1 : 0;
      if (stuff_ones == 6) begin
        send_dec(1'b0);
        stuff_ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    send_line(1'b0, 1'b1);
    send_line(1'b0, 1'b1);
    push_ev(EV_EOP, 1'b0);
    send_line(1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bitValid"}, 32'(bitValid), 0);
    check({tag, "_bitData"}, 32'(bitData), 0);
    check({tag, "_packetActive"}, 32'(packetActive), 0);
    check({tag, "_syncDetected"}, 32'(syncDetected), 0);
    check({tag, "_eopDetected"}, 32'(eopDetected), 0);
    check({tag, "_rxError"}, 32'(rxError), 0);
  endtask

  always @(negedge clk48) begin
    int         n;
    logic [1:0] kind;
    ev_t        e;
    n = int'(bitValid) + int'(syncDetected) + int'(eopDetected) + int'(rxError);
    if (n != 0) begin
      check("pulse_exclusive", 32'(n), 1);
      if (bitValid)          kind = EV_BIT;
      else if (syncDetected) kind = EV_SYNC;
      else if (eopDetected)  kind = EV_EOP;
      else                   kind = EV_ERR;
      check("sb_expected_pulse", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_kind", 32'(kind), 32'(e.kind));
        if (e.kind == EV_BIT) check("sb_bit_data", 32'(bitData), 32'(e.data));
      end
    end
  end

  initial begin
    RST        = 1'b1;
    readCLK12  = 1'b0;
    dataIn     = 1'b1;
    se0        = 1'b0;
    line_prev  = 1'b1;
    stuff_ones = 0;
    repeat (3) @(negedge clk48);
    check_all_zero("reset");
    RST = 1'b0;

    repeat (20) send_line(1'b1, 1'b0);
    check("idle_packetActive", 32'(packetActive), 0);

    // Full SYNC, payload 0xA5, clean EOP
    send_sync(7);
    check("sync7_packetActive", 32'(packetActive), 1);
    send_bits(8'hA5, 8);
    send_eop();
    check("eop_packetActive", 32'(packetActive), 0);

    // SYNC missing its first K still locks; three zeros does not
    send_sync(5);
    check("sync5_packetActive", 32'(packetActive), 1);
    send_bits(8'h3C, 8);
    send_eop();
    send_sync(3);
    repeat (3) send_line(1'b1, 1'b0);
    check("sync3_packetActive", 32'(packetActive), 0);

    // Seven 1s forces a stuffed 0 on the wire that must not surface
    send_sync(7);
    send_bits(8'h7F, 8);
    send_bits(8'h12, 8);
    send_eop();

    // Missing stuff bit
    send_sync(7);
    for (int i = 0; i < 5; i++) begin
      push_ev(EV_BIT, 1'b1);
      send_dec(1'b1);
    end
    push_ev(EV_ERR, 1'b0);
    send_dec(1'b1);
    check("stufferr_packetActive", 32'(packetActive), 0);
    send_dec(1'b1);
    send_dec(1'b1);
    repeat (2) send_line(1'b1, 1'b0);

    // SE0 followed by K is a malformed EOP
    send_sync(7);
    send_bits(8'h09, 4);
    send_line(1'b0, 1'b1);
    push_ev(EV_ERR, 1'b0);
    send_line(1'b0, 1'b0);
    check("badeop_packetActive", 32'(packetActive), 0);
    repeat (2) send_line(1'b1, 1'b0);

    // Reset in the middle of a payload, then a normal packet
    send_sync(7);
    send_bits(8'h0B, 4);
    check("prerst_packetActive", 32'(packetActive), 1);
    @(negedge clk48);
    RST    = 1'b1;
    dataIn = 1'b1;
    @(negedge clk48);
    RST = 1'b0;
    check_all_zero("midrst");
    line_prev = 1'b1;
    repeat (3) send_line(1'b1, 1'b0);
    send_sync(7);
    check("postrst_packetActive", 32'(packetActive), 1);
    send_bits(8'hC3, 8);
    send_eop();
    check("postrst_eop_packetActive", 32'(packetActive), 0);

    repeat (8) @(negedge clk48);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_bit_decoder.md
Name: usb_rx_bit_decoder

Overview:
- Downstream neighbour of the DPPL; runs in the clk48 domain.
- Uses the DPPL's readCLK12 rising edge as a bit-sample enable. On each enable it samples the synchronised line state, NRZI-decodes it, detects SYNC, removes stuffed bits and detects EOP/SE0.
- Emits one decoded payload bit per strobe to the packet deserializer, plus sync/eop/error status pulses.

Parameters:
- SYNC_MIN_ZEROS, 5: decoded 0-bits required before the terminating 1 of SYNC (legal 1..7); tolerates DPPL lock-in bit loss.
- STUFF_LEN, 6: consecutive decoded 1s after which the next bit is a stuffed 0 and is removed.

Ports:
- clk48  in  1  48 MHz clock.
- RST  in  1  synchronous, active-high reset.
- readCLK12  in  1  recovered bit clock from DPPL.
- dataIn  in  1  synchronised line state: 1 = J, 0 = K; ignored while se0=1.
- se0  in  1  synchronised SE0 indication (both lines low).
- bitValid  out  1  one-cycle strobe; a decoded payload bit is on bitData.
- bitData  out  1  decoded, unstuffed payload bit (LSB-first order as on the wire).
- packetActive  out  1  high from SYNC completion until EOP or error.
- syncDetected  out  1  one-cycle pulse on SYNC completion.
- eopDetected  out  1  one-cycle pulse on valid EOP (SE0 followed by J).
- rxError  out  1  one-cycle pulse on stuff error or malformed EOP.

Behaviour:
- Sample enable: sampleEn = readCLK12 & ~readCLK12_q; readCLK12_q resets to 1, so no spurious edge occurs after reset.
  - dataIn/se0 are taken in the sampleEn cycle.
  - All outputs are registered and appear exactly 1 clk48 cycle after the sampleEn cycle.
  - If there is no enable, all state holds and all pulses are 0.
- NRZI: decoded = (dataIn == prevLine). prevLine resets to J (1) and updates on every non-SE0 sample. On an SE0 sample it becomes J.
- Reset values: bitValid=0, bitData=0, packetActive=0, syncDetected=0, eopDetected=0, rxError=0, state=IDLE, zeroCnt=0, onesCnt=0, se0Seen=0.
- FSM states IDLE, SYNC, RECEIVE, EOP:
  - IDLE: on a K sample (se0=0, dataIn=0), set zeroCnt=1 and go to SYNC. SE0 and J samples keep IDLE.
  - SYNC:
    - decoded 0: zeroCnt saturating increment, capped at 7.
    - decoded 1 with zeroCnt >= SYNC_MIN_ZEROS: pulse syncDetected, set packetActive=1, onesCnt=1 (the SYNC's final 1 counts toward stuffing), go to RECEIVE.
    - decoded 1 with zeroCnt < SYNC_MIN_ZEROS: go to IDLE with no pulse.
    - SE0: go to IDLE with no pulse.
  - RECEIVE:
    - se0 sample: go to EOP and set se0Seen=1; no bit output.
    - onesCnt == STUFF_LEN and decoded 0: stuffed bit; drop it and set onesCnt=0.
    - onesCnt == STUFF_LEN and decoded 1: pulse rxError, set packetActive=0, go to IDLE.
    - otherwise: pulse bitValid with bitData=decoded; onesCnt = decoded ? onesCnt+1 : 0.
  - EOP:
    - further SE0 samples: stay.
    - J sample: pulse eopDetected, set packetActive=0, go to IDLE.
    - K sample: pulse rxError, set packetActive=0, go to IDLE.
- Pulse exclusivity: bitValid, syncDetected, eopDetected and rxError are mutually exclusive in any cycle.
- RST mid-packet: all state and outputs return to reset values in the next cycle. No eop/error pulse is generated.
- Widths: zeroCnt and onesCnt are 3 bits. No counter wraps; zeroCnt saturates at 7, and onesCnt is bounded by STUFF_LEN via the stuff rule.

Decomposition:
- Package usb_rx_pkg holds:
  - RX_DEC_STATE enum (IDLE, SYNC, RECEIVE, EOP);
  - LINE_J = 1'b1 and LINE_K = 1'b0;
  - STUFF_LEN_DEFAULT.
- One natural sub-module, usb_nrzi_unstuffer. It owns prevLine, onesCnt and the stuffed-bit drop/error decision, and outputs decodedBit, dropBit and stuffErr per enable. The FSM stays in the top module.

Test Plan:
- Reset then idle J for 20 bit times: all outputs 0, packetActive=0.
- Line KJKJKJKK, then payload decoding to 0xA5 LSB-first:
  - syncDetected 1 cycle after the 8th sample;
  - then 8 bitValid strobes with bitData = 1,0,1,0,0,1,0,1;
  - then SE0, SE0, J gives eopDetected and packetActive falls.
- SYNC with first K lost (KJKJKKK…, 5 zeros), SYNC_MIN_ZEROS=5: syncDetected still asserts. With only 3 zeros before the 1: no sync, back to IDLE.
- Payload of seven 1-bits:
  - wire carries 6 ones (counting SYNC's trailing 1), a stuffed 0, then the rest;
  - exactly 7 bitValid=1/bitData=1 strobes plus the following payload; the stuffed bit never appears.
- Seven consecutive decoded 1s (no stuff bit) during RECEIVE: rxError pulse, packetActive=0, no further bitValid.
- SE0 then K in RECEIVE gives rxError. Assert RST mid-payload: next cycle all outputs are 0, and a new SYNC is then accepted normally.
